updown_counter_ctrl: RTL and testbench



---
 rtl/updown_counter_ctrl.sv | 103 ++++++++++
 tb/tb_updown_counter_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_ctrl.sv
// Parametrised up/down counter with modulo limit, wrap/saturate, load, clear, tc pulse and sticky ovf.
// Define UPDOWN_COUNTER_PRESCALE_EN to build the enable prescaler (step once per prescale+1 enabled cycles).
module updown_counter_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  logic             tick;
  logic [WIDTH-1:0] q_d;
  logic             tc_d;
  logic             ovf_d;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // Prescaler: counts enabled cycles, fires tick when it reaches the programmed ratio.
  always_comb begin
    tick  = (pre_q == prescale);
    pre_d = pre_q;
    if (clr || load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick            = 1'b1;
`endif

  // Next count: clr > load > step; a boundary step raises tc for one cycle and sets ovf.
  always_comb begin
    q_d   = q;
    tc_d  = 1'b0;
    ovf_d = ovf;
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = (load_val > limit) ? limit : load_val;
    end else if (en && tick) begin
      if (up) begin
        if (q < limit) begin
          q_d = q + WIDTH'(1);
        end else begin
          q_d   = sat_mode ? limit : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end else begin
        if (q != '0) begin
          q_d = q - WIDTH'(1);
        end else begin
          q_d   = sat_mode ? '0 : limit;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_d;
      tc  <= tc_d;
      ovf <= ovf_d;
    end
  end

  assign at_max = (q >= limit);
  assign at_min = (q == '0);

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Scoreboard bench for updown_counter_ctrl: directed scenarios then randomized traffic vs. an integer model.
module tb_updown_counter_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PRE_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, up, clr, load, sat_mode;
  logic [WIDTH-1:0] load_val, limit;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] q;
  logic             tc, ovf, at_max, at_min;

  updown_counter_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .sat_mode(sat_mode), .prescale(prescale),
    .q(q), .tc(tc), .ovf(ovf), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic             at_max;
    logic             at_min;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state, kept as plain integers.
  int m_q = 0;
  int m_ovf = 0;
  int m_pre = 0;

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic u, input logic c, input logic l,
                     input int lv, input int lim, input logic s, input int ps, input string tag);
    exp_t x;
    int   m_tc;
    bit   tick;
    @(negedge clk);
    rst_n = r; en = e; up = u; clr = c; load = l;
    load_val = WIDTH'(lv); limit = WIDTH'(lim); sat_mode = s; prescale = PRE_W'(ps);
    m_tc = 0;
    if (!r || c) begin
      m_q = 0; m_ovf = 0; m_pre = 0;
    end else if (l) begin
      m_q = (lv < lim) ? lv : lim;
      m_pre = 0;
    end else if (e) begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
      m_pre = (m_pre + 1) % (ps + 1);
      tick  = (m_pre == 0);
`else
      tick  = 1'b1;
`endif
      if (tick) begin
        if (u && m_q < lim)        m_q = m_q + 1;
        else if (!u && m_q > 0)    m_q = m_q - 1;
        else begin
          m_tc = 1; m_ovf = 1;
          if (u) m_q = s ? lim : 0;
          else   m_q = s ? 0 : lim;
        end
      end
    end
    x.q      = WIDTH'(m_q);
    x.tc     = (m_tc != 0);
    x.ovf    = (m_ovf != 0);
    x.at_max = (m_q >= lim);
    x.at_min = (m_q == 0);
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  // Monitor: each rising edge the DUT presents a new state; compare it against the oldest expectation.
  initial begin
    exp_t  x;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        if (q !== x.q || tc !== x.tc || ovf !== x.ovf || at_max !== x.at_max || at_min !== x.at_min) begin
          miscompares++;
          $display("FAIL %s: got q=%0d tc=%b ovf=%b at_max=%b at_min=%b, want q=%0d tc=%b ovf=%b at_max=%b at_min=%b",
                   t, q, tc, ovf, at_max, at_min, x.q, x.tc, x.ovf, x.at_max, x.at_min);
        end
      end
    end
  end

  initial begin
    int lim, s, ps, drain;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0; limit = '0; sat_mode = 1'b0; prescale = '0;

    // Reset, then free-running wrap over the full range.
    cyc(0, 0, 1, 0, 0, 0, 255, 0, 0, "reset");
    cyc(0, 1, 1, 0, 0, 0, 255, 0, 0, "reset_en");
    for (int i = 0; i < 258; i++) cyc(1, 1, 1, 0, 0, 0, 255, 0, 0, "free_wrap");

    // Down wrap from zero to the limit.
    cyc(1, 0, 1, 1, 0, 0, 9, 0, 0, "clr");
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 9, 0, 0, "down_wrap");

    // Load clipped to the limit, saturating up steps, then clear.
    cyc(1, 0, 1, 0, 1, 200, 5, 1, 0, "load_clip");
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 5, 1, 0, "sat_up");
    cyc(1, 0, 1, 1, 0, 0, 5, 1, 0, "clr_ovf");

    // Priority: clr over load, load over step, reset over everything.
    cyc(1, 0, 1, 0, 1, 3, 255, 0, 0, "load3");
    cyc(1, 1, 1, 1, 1, 7, 255, 0, 0, "clr_load");
    cyc(1, 1, 1, 0, 1, 7, 255, 0, 0, "load_en");
    cyc(0, 1, 1, 0, 0, 0, 255, 0, 0, "rst_mid");

    // Limit lowered below q.
    for (s = 0; s < 2; s++) begin
      cyc(1, 0, 1, 0, 1, 50, 100, s[0], 0, "load50");
      cyc(1, 1, 1, 0, 0, 0, 20, s[0], 0, "lim_drop_up");
    end
    cyc(1, 0, 1, 0, 1, 50, 100, 0, 0, "load50");
    cyc(1, 1, 0, 0, 0, 0, 20, 0, 0, "lim_drop_down");

    // limit = 0: every step is a boundary.
    for (int i = 0; i < 4; i++) cyc(1, 1, i[0], 0, 0, 0, 0, i[1], 0, "lim_zero");

    // Prescale 3 with an enable gap.
    cyc(1, 0, 1, 1, 0, 0, 255, 0, 3, "pre_clr");
    for (int i = 0; i < 14; i++) cyc(1, (i != 5 && i != 6), 1, 0, 0, 0, 255, 0, 3, "prescale");

    // Randomized traffic; prescale only changes alongside a clear.
    lim = 255; s = 0; ps = 0;
    for (int i = 0; i < 2000; i++) begin
      logic r, e, u, c, l;
      r = ($urandom_range(63) != 0);
      c = ($urandom_range(31) == 0);
      l = ($urandom_range(15) == 0);
      e = ($urandom_range(3) != 0);
      u = ($urandom_range(2) != 0) ^ (i[8] == 1'b1);
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(3))
          0: lim = 0;
          1: lim = 255;
          2: lim = $urandom_range(15);
          default: lim = $urandom_range(255);
        endcase
        s = $urandom_range(1);
      end
      if (c || !r) ps = $urandom_range(3);
      cyc(r, e, u, c, l, $urandom_range(255), lim, s[0], ps, "random");
    end

    // Bounded drain of outstanding expectations.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      #2;
      drain++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
